mem_word_access_ctrl: RTL and testbench

- CPU-side initiator for the byte-wide data memory: turns one 28-bit word load/store into four sequential byte accesses.
- Write path: splits the word into bytes (little-endian).
- Read path: collects the four bytes and reassembles the word.
- Sits between the CPU execute stage and the 256x8 memory. The memory reads combinationally and writes synchronously.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_byte_lane.sv | 38 +++
 rtl/mem_word_access_ctrl.sv | 107 ++++++++++
 tb/tb_mem_word_access_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, derived constants and FSM encoding for the word-to-byte memory access controller.
package mem_pkg;
    localparam int ADDR_W         = 28;
    localparam int DATA_W         = 28;
    localparam int BYTE_W         = 8;
    localparam int MEM_DEPTH      = 256;
    localparam int BYTES_PER_WORD = 4;
    localparam int LAST_BYTE_BITS = DATA_W - 3 * BYTE_W;
    localparam int K_W            = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Highest legal base is MEM_DEPTH - BYTES_PER_WORD, so the whole word stays inside memory.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] a);
        return a > ADDR_W'(MEM_DEPTH - BYTES_PER_WORD);
    endfunction
endpackage

// File: rtl/mem_byte_lane.sv
// Byte lane select: extracts byte k of the store word and inserts a read byte at lane k.
// Latency: combinational. Backpressure: none (pure datapath).
// The top lane is only LAST_BYTE_BITS wide; its upper memory bits are dropped on reads.
module mem_byte_lane
    import mem_pkg::*;
(
    input  logic [K_W-1:0]    k,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic [BYTE_W-1:0] rd_byte,
    output logic [DATA_W-1:0] wr_word,
    output logic [DATA_W-1:0] rdata_nxt
);

    always_comb begin
        wr_word   = '0;
        rdata_nxt = rdata;
        case (k)
            K_W'(0): begin
                wr_word[BYTE_W-1:0]     = wdata[BYTE_W-1:0];
                rdata_nxt[BYTE_W-1:0]   = rd_byte;
            end
            K_W'(1): begin
                wr_word[BYTE_W-1:0]            = wdata[2*BYTE_W-1:BYTE_W];
                rdata_nxt[2*BYTE_W-1:BYTE_W]   = rd_byte;
            end
            K_W'(2): begin
                wr_word[BYTE_W-1:0]              = wdata[3*BYTE_W-1:2*BYTE_W];
                rdata_nxt[3*BYTE_W-1:2*BYTE_W]   = rd_byte;
            end
            default: begin
                wr_word[LAST_BYTE_BITS-1:0]      = wdata[DATA_W-1:3*BYTE_W];
                rdata_nxt[DATA_W-1:3*BYTE_W]     = rd_byte[LAST_BYTE_BITS-1:0];
            end
        endcase
    end

endmodule

// File: rtl/mem_word_access_ctrl.sv
// Word load/store to four little-endian byte accesses; MEM_ALIGN_CHECK_EN also rejects unaligned addresses.
// Latency: response 5 cycles after accept (1 cycle for a rejected request).
// Backpressure: req_ready only in IDLE; requests seen while busy are dropped; response cannot stall.
module mem_word_access_ctrl
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_out
);

    state_t            state, state_nxt;
    logic [K_W-1:0]    k;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [DATA_W-1:0] lane_wr, lane_rd_nxt;
    logic              req_err;
    logic              accept;
    logic              unused_mem_hi;

    assign unused_mem_hi = ^mem_out[DATA_W-1:BYTE_W];
    assign accept        = req_valid && req_ready;

`ifdef MEM_ALIGN_CHECK_EN
    assign req_err = addr_out_of_range(req_addr) || (req_addr[1:0] != 2'b00);
`else
    assign req_err = addr_out_of_range(req_addr);
`endif

    mem_byte_lane u_lane (
        .k         (k),
        .wdata     (wdata_q),
        .rdata     (rdata_q),
        .rd_byte   (mem_out[BYTE_W-1:0]),
        .wr_word   (lane_wr),
        .rdata_nxt (lane_rd_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= req_we;
                err_q   <= req_err;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                k       <= '0;
            end else if (state == ACCESS) begin
                k <= k + K_W'(1);
                if (!we_q) rdata_q <= lane_rd_nxt;
            end
        end
    end

    // Every memory-side output is decoded from registered state, never from req_*.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_addr   = '0;
        mem_in     = '0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_err ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_addr = addr_q + ADDR_W'(k);
                mem_we   = we_q;
                mem_in   = we_q ? lane_wr : '0;
                if (k == K_W'(BYTES_PER_WORD - 1)) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? '0 : rdata_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_word_access_ctrl.sv
// Directed bench for mem_word_access_ctrl with a behavioural 256x8 memory (comb read, sync write, sync clear).
module tb_mem_word_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [27:0] req_addr = '0;
    logic [27:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [27:0] resp_rdata;
    logic [27:0] mem_addr;
    logic [27:0] mem_in;
    logic        mem_we;
    logic [27:0] mem_out;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_viol  = 0;

    logic [7:0] mem [0:255];
    logic       pl_we = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_dat = '0;

    mem_word_access_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_in     (mem_in),
        .mem_we     (mem_we),
        .mem_out    (mem_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_dat;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_in[7:0];
        end
    end

    assign mem_out = {20'h0, mem[mem_addr[7:0]]};

    always @(negedge clk) begin
        if (rst_n && mem_in[27:8] !== 20'h0) hi_viol++;
    end

    // One request, then observe 8 cycles; cycle c is the c-th cycle after the accepting edge.
    task automatic run_req(input logic we, input logic [27:0] addr, input logic [27:0] wd,
                           output logic rdy0, output int rcyc, output int npulse,
                           output logic rerr, output logic [27:0] rdat, output int wecnt);
        @(negedge clk);
        rdy0      = req_ready;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rcyc = -1; npulse = 0; wecnt = 0; rerr = 1'b0; rdat = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we === 1'b1) wecnt++;
            if (resp_valid === 1'b1) begin
                npulse++;
                if (rcyc < 0) begin
                    rcyc = c;
                    rerr = resp_err;
                    rdat = resp_rdata;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/rv/err/we=%b expected 1000", {req_ready, resp_valid, resp_err, mem_we});
        end
        n_checks++;
        if (resp_rdata !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0", resp_rdata);
        end
        n_checks++;
        if ({mem_addr, mem_in} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got addr %h in %h expected 0 0", mem_addr, mem_in);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_store;
        logic r0, re; int rc, np, wc; logic [27:0] rd;
        run_req(1'b1, 28'h10, 28'hA5B3C7D, r0, rc, np, re, rd, wc);
        n_checks++;
        if (r0 !== 1'b1) begin n_fail++; $display("FAIL store_ready: got %b expected 1", r0); end
        n_checks++;
        if (rc !== 5 || np !== 1) begin
            n_fail++; $display("FAIL store_resp_timing: got cycle %0d pulses %0d expected 5 1", rc, np);
        end
        n_checks++;
        if (re !== 1'b0 || rd !== 28'h0) begin
            n_fail++; $display("FAIL store_resp_fields: got err %b rdata %h expected 0 0", re, rd);
        end
        n_checks++;
        if (wc !== 4) begin n_fail++; $display("FAIL store_we_cycles: got %0d expected 4", wc); end
        n_checks++;
        if ({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} !== 32'h0A5B3C7D) begin
            n_fail++;
            $display("FAIL store_mem_bytes: got %h expected 0a5b3c7d", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]});
        end
    endtask

    task automatic test_load;
        logic r0, re; int rc, np, wc; logic [27:0] rd;
        run_req(1'b0, 28'h10, 28'hFFFFFFF, r0, rc, np, re, rd, wc);
        n_checks++;
        if (rc !== 5 || np !== 1 || re !== 1'b0) begin
            n_fail++; $display("FAIL load_resp: got cycle %0d pulses %0d err %b expected 5 1 0", rc, np, re);
        end
        n_checks++;
        if (rd !== 28'hA5B3C7D) begin n_fail++; $display("FAIL load_rdata: got %h expected a5b3c7d", rd); end
        n_checks++;
        if (wc !== 0) begin n_fail++; $display("FAIL load_no_write: got %0d we cycles expected 0", wc); end
    endtask

    task automatic test_boundary;
        logic r0, re; int rc, np, wc; logic [27:0] rd;
        run_req(1'b1, 28'hFC, 28'h1234567, r0, rc, np, re, rd, wc);
        n_checks++;
        if (rc !== 5 || re !== 1'b0 || wc !== 4) begin
            n_fail++; $display("FAIL bnd_store_fc: got cycle %0d err %b we %0d expected 5 0 4", rc, re, wc);
        end
        run_req(1'b0, 28'hFC, 28'h0, r0, rc, np, re, rd, wc);
        n_checks++;
        if (rc !== 5 || re !== 1'b0 || rd !== 28'h1234567) begin
            n_fail++; $display("FAIL bnd_load_fc: got cycle %0d err %b rdata %h expected 5 0 1234567", rc, re, rd);
        end
        run_req(1'b1, 28'hFD, 28'hFFFFFFF, r0, rc, np, re, rd, wc);
        n_checks++;
        if (rc !== 1 || np !== 1 || re !== 1'b1 || rd !== 28'h0 || wc !== 0) begin
            n_fail++;
            $display("FAIL bnd_store_fd: got cycle %0d pulses %0d err %b rdata %h we %0d expected 1 1 1 0 0", rc, np, re, rd, wc);
        end
        n_checks++;
        if (mem[8'hFF] !== 8'h01) begin n_fail++; $display("FAIL bnd_fd_untouched: got %h expected 01", mem[8'hFF]); end
        run_req(1'b1, 28'h100, 28'hFFFFFFF, r0, rc, np, re, rd, wc);
        n_checks++;
        if (rc !== 1 || re !== 1'b1 || wc !== 0) begin
            n_fail++; $display("FAIL bnd_store_100: got cycle %0d err %b we %0d expected 1 1 0", rc, re, wc);
        end
        n_checks++;
        if (mem[8'h00] !== 8'h00) begin n_fail++; $display("FAIL bnd_100_no_wrap: got %h expected 00", mem[8'h00]); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] rdy_v, rsp_v;
        logic [27:0] rd1, rd2;
        logic        err_any;
        rdy_v = '0; rsp_v = '0; rd1 = '0; rd2 = '0; err_any = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h10; req_wdata = 28'h0;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            rdy_v[c-1] = req_ready;
            rsp_v[c-1] = resp_valid;
            if (resp_valid === 1'b1) begin
                if (c <= 6) rd1 = resp_rdata; else rd2 = resp_rdata;
                err_any = err_any | resp_err;
            end
            if (c == 2)  req_addr = 28'h200;
            if (c == 5)  req_addr = 28'h10;
            if (c == 12) req_valid = 1'b0;
        end
        n_checks++;
        if (rdy_v !== 12'h820) begin n_fail++; $display("FAIL b2b_ready: got %b expected 100000100000", rdy_v); end
        n_checks++;
        if (rsp_v !== 12'h410) begin n_fail++; $display("FAIL b2b_resp: got %b expected 010000010000", rsp_v); end
        n_checks++;
        if (rd1 !== 28'hA5B3C7D || rd2 !== 28'hA5B3C7D || err_any !== 1'b0) begin
            n_fail++; $display("FAIL b2b_data: got %h %h err %b expected a5b3c7d a5b3c7d 0", rd1, rd2, err_any);
        end
    endtask

    task automatic test_unaligned;
        logic r0, re; int rc, np, wc; logic [27:0] rd;
`ifdef MEM_ALIGN_CHECK_EN
        run_req(1'b0, 28'h11, 28'h0, r0, rc, np, re, rd, wc);
        n_checks++;
        if (rc !== 1 || re !== 1'b1 || rd !== 28'h0 || wc !== 0) begin
            n_fail++; $display("FAIL unaligned_load: got cycle %0d err %b rdata %h we %0d expected 1 1 0 0", rc, re, rd, wc);
        end
`else
        run_req(1'b1, 28'h11, 28'h0123ABC, r0, rc, np, re, rd, wc);
        run_req(1'b0, 28'h11, 28'h0, r0, rc, np, re, rd, wc);
        n_checks++;
        if (rc !== 5 || re !== 1'b0 || rd !== 28'h0123ABC) begin
            n_fail++; $display("FAIL unaligned_load: got cycle %0d err %b rdata %h expected 5 0 0123abc", rc, re, rd);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int npulse;
        npulse = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 28'h40; req_wdata = 28'hFFFFFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem_addr !== 28'h42 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_k2: got addr %h we %b expected 42 1", mem_addr, mem_we);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, mem_we, resp_valid} !== 3'b100 || mem_addr !== 28'h0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got rdy/we/rv=%b addr %h expected 100 0", {req_ready, mem_we, resp_valid}, mem_addr);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) npulse++;
        end
        n_checks++;
        if (npulse !== 0) begin n_fail++; $display("FAIL rstmid_no_resp: got %0d pulses expected 0", npulse); end
    endtask

    task automatic test_byte3_nibble;
        logic r0, re; int rc, np, wc; logic [27:0] rd;
        logic [7:0] pat [4];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'hF4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pl_we = 1'b1; pl_addr = 8'h30 + 8'(i); pl_dat = pat[i];
        end
        @(negedge clk);
        pl_we = 1'b0;
        run_req(1'b0, 28'h30, 28'h0, r0, rc, np, re, rd, wc);
        n_checks++;
        if (rc !== 5 || rd !== 28'h4332211) begin
            n_fail++; $display("FAIL byte3_nibble: got cycle %0d rdata %h expected 5 4332211", rc, rd);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_boundary();
        test_back_to_back();
        test_unaligned();
        test_reset_mid();
        test_byte3_nibble();
        n_checks++;
        if (hi_viol !== 0) begin n_fail++; $display("FAIL mem_in_upper_zero: got %0d violations expected 0", hi_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
